croc_artya7_gpio_pads: RTL and testbench

//  Board-level GPIO pad controller between croc_soc GPIO signals and the FPGA I/O buffers.
//  It generalises the plain tristate hookup with the following features:
//  - registered output/enable path
//  - per-pin open-drain mode
//  - input synchronisation and per-pin debounce
//  - per-pin rising/falling edge event pulses
//  The FPGA top keeps only the IOBUF: gpio[i] = pad_oe_o[i] ? pad_o[i] : 'z; pad_i = gpio.

---
 rtl/croc_artya7_pkg.sv | 33 +++
 rtl/croc_artya7_gpio_debounce.sv | 61 ++++++
 rtl/croc_artya7_gpio_pads.sv | 67 ++++++
 tb/tb_croc_artya7_gpio_pads.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/croc_artya7_pkg.sv
// Shared types and defaults for the Arty A7 croc_soc board glue.
// The per-pin pad drive rule lives here so every pin applies it identically.
package croc_artya7_pkg;

  localparam int GpioCountDefault      = 16;
  localparam int SyncStagesDefault     = 2;
  localparam int DebounceCyclesDefault = 1000;  // 10 us at 100 MHz clk_sys

  typedef logic [GpioCountDefault-1:0] gpio_vec_t;

  typedef enum logic {
    PAD_PUSH_PULL  = 1'b0,
    PAD_OPEN_DRAIN = 1'b1
  } pad_mode_e;

  typedef struct packed {
    logic o;
    logic oe;
  } pad_drive_t;

  // Open-drain pins only ever pull low; a logic 1 releases the pad.
  function automatic pad_drive_t pad_drive(input logic o, input logic oe, input pad_mode_e mode);
    pad_drive_t d;
    d.o  = o;
    d.oe = oe;
    if (mode == PAD_OPEN_DRAIN) begin
      d.o  = 1'b0;
      d.oe = oe & ~o;
    end
    return d;
  endfunction

endpackage

// File: rtl/croc_artya7_gpio_debounce.sv
// One GPIO input pin: synchroniser, stability counter, debounced level and
// single-cycle rise/fall event pulses aligned with the debounced level change.
module croc_artya7_gpio_debounce
  import croc_artya7_pkg::*;
#(
  parameter int SyncStages     = SyncStagesDefault,
  parameter int DebounceCycles = DebounceCyclesDefault
) (
  input  logic clk_i,
  input  logic rst,
  input  logic pad_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("croc_artya7_gpio_debounce: SyncStages must be >= 2");
  end
  if (DebounceCycles < 1) begin : g_bad_debounce_cycles
    $error("croc_artya7_gpio_debounce: DebounceCycles must be >= 1");
  end

  localparam int CntWidth = $clog2(DebounceCycles + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  logic [SyncStages-1:0] r_sync;
  logic [CntWidth-1:0]   r_cnt;
  logic                  r_deb;
  logic                  r_deb_d1;
  logic                  w_sync;

  assign w_sync = r_sync[SyncStages-1];

  always_ff @(posedge clk_i) begin
    if (rst) begin
      // NOTE: the synchroniser chain is reset as well, so a pin held high
      // through reset is re-qualified from zero rather than seen instantly.
      r_sync   <= '0;
      r_cnt    <= '0;
      r_deb    <= 1'b0;
      r_deb_d1 <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SyncStages-2:0], pad_i};
      r_deb_d1 <= r_deb;
      if (w_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_deb <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntWidth'(1);
      end
    end
  end

  assign deb_o  = r_deb;
  assign rise_o = r_deb & ~r_deb_d1;
  assign fall_o = ~r_deb & r_deb_d1;

endmodule

// File: rtl/croc_artya7_gpio_pads.sv
// GPIO pad controller between croc_soc and the FPGA IOBUFs: registered
// push-pull/open-drain output drive plus debounced inputs with edge events.
module croc_artya7_gpio_pads
  import croc_artya7_pkg::*;
#(
  parameter int GpioCount      = GpioCountDefault,
  parameter int SyncStages     = SyncStagesDefault,
  parameter int DebounceCycles = DebounceCyclesDefault
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic [GpioCount-1:0] soc_gpio_o_i,
  input  logic [GpioCount-1:0] soc_gpio_oe_i,
  input  logic [GpioCount-1:0] od_en_i,
  output logic [GpioCount-1:0] soc_gpio_i_o,
  output logic [GpioCount-1:0] gpio_rise_o,
  output logic [GpioCount-1:0] gpio_fall_o,
  input  logic [GpioCount-1:0] pad_i,
  output logic [GpioCount-1:0] pad_o,
  output logic [GpioCount-1:0] pad_oe_o
);

  logic [GpioCount-1:0] w_pad_o_nxt;
  logic [GpioCount-1:0] w_pad_oe_nxt;
  logic [GpioCount-1:0] r_pad_o;
  logic [GpioCount-1:0] r_pad_oe;

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    w_pad_o_nxt  = '0;
    w_pad_oe_nxt = '0;
    for (int i = 0; i < GpioCount; i++) begin
      {w_pad_o_nxt[i], w_pad_oe_nxt[i]} =
        pad_drive(soc_gpio_o_i[i], soc_gpio_oe_i[i], pad_mode_e'(od_en_i[i]));
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_pad_o  <= '0;
      r_pad_oe <= '0;
    end else begin
      r_pad_o  <= w_pad_o_nxt;
      r_pad_oe <= w_pad_oe_nxt;
    end
  end

  assign pad_o    = r_pad_o;
  assign pad_oe_o = r_pad_oe;

  for (genvar g = 0; g < GpioCount; g++) begin : g_pin
    croc_artya7_gpio_debounce #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst    (rst),
      .pad_i  (pad_i[g]),
      .deb_o  (soc_gpio_i_o[g]),
      .rise_o (gpio_rise_o[g]),
      .fall_o (gpio_fall_o[g])
    );
  end

endmodule

// File: tb/tb_croc_artya7_gpio_pads.sv
// Self-checking bench for croc_artya7_gpio_pads with SyncStages=2, DebounceCycles=4.
module tb_croc_artya7_gpio_pads;
  import croc_artya7_pkg::*;

  localparam int SyncStages     = 2;
  localparam int DebounceCycles = 4;
  localparam int Lat            = SyncStages + DebounceCycles;

  logic      clk_i = 1'b0;
  logic      rst;
  gpio_vec_t soc_gpio_o_i, soc_gpio_oe_i, od_en_i, pad_i;
  gpio_vec_t soc_gpio_i_o, gpio_rise_o, gpio_fall_o, pad_o, pad_oe_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    gpio_vec_t od;
    gpio_vec_t oe;
    gpio_vec_t o;
    gpio_vec_t exp_o;
    gpio_vec_t exp_oe;
  } out_vec_t;

  typedef struct {
    gpio_vec_t exp_o;
    gpio_vec_t exp_oe;
  } sb_entry_t;

  out_vec_t  vecs[6];
  sb_entry_t sb_q[$];

  croc_artya7_gpio_pads #(
    .GpioCount      (16),
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) dut (
    .clk_i         (clk_i),
    .rst           (rst),
    .soc_gpio_o_i  (soc_gpio_o_i),
    .soc_gpio_oe_i (soc_gpio_oe_i),
    .od_en_i       (od_en_i),
    .soc_gpio_i_o  (soc_gpio_i_o),
    .gpio_rise_o   (gpio_rise_o),
    .gpio_fall_o   (gpio_fall_o),
    .pad_i         (pad_i),
    .pad_o         (pad_o),
    .pad_oe_o      (pad_oe_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input gpio_vec_t act, input gpio_vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_deb"},   soc_gpio_i_o, '0);
    check({name, "_rise"},  gpio_rise_o,  '0);
    check({name, "_fall"},  gpio_fall_o,  '0);
    check({name, "_pad_o"}, pad_o,        '0);
    check({name, "_oe"},    pad_oe_o,     '0);
  endtask

  // Input levels were last changed (or reset released) just after an edge;
  // the debounced level must switch exactly Lat edges later.
  task automatic settle_seq(input string name, input gpio_vec_t old_deb,
                            input gpio_vec_t new_deb, input int n);
    gpio_vec_t e_deb, e_rise, e_fall;
    for (int k = 1; k <= n; k++) begin
      tick();
      e_deb  = (k >= Lat) ? new_deb : old_deb;
      e_rise = (k == Lat) ? (new_deb & ~old_deb) : '0;
      e_fall = (k == Lat) ? (old_deb & ~new_deb) : '0;
      check($sformatf("%s_deb_c%0d", name, k),  soc_gpio_i_o, e_deb);
      check($sformatf("%s_rise_c%0d", name, k), gpio_rise_o,  e_rise);
      check($sformatf("%s_fall_c%0d", name, k), gpio_fall_o,  e_fall);
    end
  endtask

  initial begin
    sb_entry_t got;

    vecs[0] = '{od: 16'h0000, oe: 16'hFFFF, o: 16'hA5A5, exp_o: 16'hA5A5, exp_oe: 16'hFFFF};
    vecs[1] = '{od: 16'h0001, oe: 16'hFFFF, o: 16'hA5A5, exp_o: 16'hA5A4, exp_oe: 16'hFFFE};
    vecs[2] = '{od: 16'h0001, oe: 16'hFFFF, o: 16'hA5A4, exp_o: 16'hA5A4, exp_oe: 16'hFFFF};
    vecs[3] = '{od: 16'hFFFF, oe: 16'h00FF, o: 16'h0F0F, exp_o: 16'h0000, exp_oe: 16'h00F0};
    vecs[4] = '{od: 16'h0000, oe: 16'h1234, o: 16'h5678, exp_o: 16'h5678, exp_oe: 16'h1234};
    vecs[5] = '{od: 16'h00FF, oe: 16'hFFFF, o: 16'hFFFF, exp_o: 16'hFF00, exp_oe: 16'hFF00};

    // 1. Reset for 3 cycles with all pads high.
    rst = 1'b1;
    pad_i = 16'hFFFF;
    soc_gpio_o_i = '0;
    soc_gpio_oe_i = '0;
    od_en_i = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all_zero($sformatf("reset_c%0d", c));
    end
    rst = 1'b0;
    settle_seq("por_high", 16'h0000, 16'hFFFF, Lat + 2);

    // 2/3. Output path through the scoreboard, one cycle latency.
    for (int i = 0; i < 6; i++) begin
      od_en_i       = vecs[i].od;
      soc_gpio_oe_i = vecs[i].oe;
      soc_gpio_o_i  = vecs[i].o;
      sb_q.push_back('{exp_o: vecs[i].exp_o, exp_oe: vecs[i].exp_oe});
      tick();
      if (sb_q.size() == 0) begin
        check($sformatf("sb_empty_v%0d", i), 16'h0000, 16'h0001);
      end else begin
        got = sb_q.pop_front();
        check($sformatf("pad_o_v%0d", i),  pad_o,    got.exp_o);
        check($sformatf("pad_oe_v%0d", i), pad_oe_o, got.exp_oe);
      end
    end

    // Bring every input low so single-pin events can be observed.
    pad_i = 16'h0000;
    settle_seq("all_low", 16'hFFFF, 16'h0000, Lat + 2);

    // 4. Single pin rise and fall.
    pad_i = 16'h0008;
    settle_seq("pin3_rise", 16'h0000, 16'h0008, Lat + 2);
    pad_i = 16'h0000;
    settle_seq("pin3_fall", 16'h0008, 16'h0000, Lat + 2);

    // 5. A 3-sample glitch is shorter than the qualification window.
    pad_i = 16'h0020;
    for (int k = 1; k <= 3; k++) tick();
    pad_i = 16'h0000;
    for (int k = 1; k <= Lat + 2; k++) begin
      tick();
      check($sformatf("glitch_deb_c%0d", k),  soc_gpio_i_o, '0);
      check($sformatf("glitch_rise_c%0d", k), gpio_rise_o,  '0);
      check($sformatf("glitch_fall_c%0d", k), gpio_fall_o,  '0);
    end

    // 6. Reset pulse mid-qualification restarts the count.
    pad_i = 16'h0080;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("pre_rst_deb_c%0d", k), soc_gpio_i_o, '0);
    end
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    settle_seq("pin7_after_rst", 16'h0000, 16'h0080, Lat + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
